// File: rtl/spwm_param_calc_pkg.sv
// Shared types and elaboration helpers for the SPWM parameter calculator.
// Rounding division is selected with SPWM_ROUND_EN.
package spwm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DIV1,
      DIV2,
      ZERO1,
      ZERO2,
      DONE
   } state_e;

   function automatic int unsigned quarter_of(input int unsigned pwm_hz);
      return pwm_hz / 4;
   endfunction

   function automatic int unsigned period_of(input int unsigned clk_hz,
                                             input int unsigned pwm_hz);
      return clk_hz / pwm_hz;
   endfunction

   // Clamp an unsigned value to the largest w-bit number.
   function automatic logic [31:0] sat_u(input logic [31:0] x,
                                         input int unsigned w);
      logic [31:0] lim;
      lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (x > lim) ? lim : x;
   endfunction

endpackage

// File: rtl/spwm_param_calc_if.sv
// Start/result bundle between frequency selector, calculator and generator.
// The calculator sits on the slave side.
interface spwm_param_calc_if #(
   parameter int unsigned FREC_W   = 8,
   parameter int unsigned CICLOS_W = 11,
   parameter int unsigned CTE_W    = 16
);
   logic                Start;
   logic [FREC_W-1:0]   Frec;
   logic                Busy;
   logic                Valid;
   logic                Err;
   logic [CICLOS_W-1:0] Ciclos_pwm;
   logic [CTE_W-1:0]    Cte;

   modport master (
      output Start, Frec,
      input  Busy, Valid, Err, Ciclos_pwm, Cte
   );

   modport slave (
      input  Start, Frec,
      output Busy, Valid, Err, Ciclos_pwm, Cte
   );
endinterface

// File: rtl/spwm_seq_div.sv
// Restoring divider, one quotient bit per clock, W clocks per division.
// Dividend carries one extra MSB so a rounding bias fits without widening W.
module spwm_seq_div #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [W:0]   dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic         done_o,
   output logic         dbz_o,
   output logic [W-1:0] quot_o
);
   localparam int unsigned CW = $clog2(W + 1);

   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          act_q, act_d;
   logic [W:0]    trial;
   logic          ge;

   assign trial  = {rem_q, quo_q[W-1]};
   assign ge     = (trial >= {1'b0, divisor_i});
   assign quot_o = {quo_q[W-2:0], ge};
   assign done_o = act_q && (cnt_q == CW'(1));
   assign dbz_o  = act_q && (divisor_i == '0);

   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      cnt_d = cnt_q;
      act_d = act_q;
      if (start_i) begin
         // The extra MSB is always below the divisor, so it seeds the remainder.
         rem_d = {{(W-1){1'b0}}, dividend_i[W]};
         quo_d = dividend_i[W-1:0];
         cnt_d = CW'(W);
         act_d = 1'b1;
      end else if (act_q) begin
         rem_d = ge ? W'(trial - {1'b0, divisor_i}) : trial[W-1:0];
         quo_d = quot_o;
         cnt_d = cnt_q - CW'(1);
         act_d = (cnt_q != CW'(1));
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rem_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
         act_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_d;
         act_q <= act_d;
      end
   end
endmodule

// File: rtl/spwm_param_calc.sv
// Computes carrier cycles per sine quarter and duty increment from Frec.
// Define SPWM_ROUND_EN for round-to-nearest division.
module spwm_param_calc
   import spwm_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned PWM_HZ   = 5_000,
   parameter int unsigned FREC_W   = 8,
   parameter int unsigned CICLOS_W = 11,
   parameter int unsigned CTE_W    = 16,
   parameter int unsigned DIV_W    = 16
) (
   input  logic               Clk,
   input  logic               Rst_n,
   spwm_param_calc_if.slave   bus
);
   localparam int unsigned QUARTER = quarter_of(PWM_HZ);
   localparam int unsigned PERIOD  = period_of(CLK_HZ, PWM_HZ);
   localparam logic [DIV_W:0] QUARTER_V = (DIV_W+1)'(QUARTER);
   localparam logic [DIV_W:0] PERIOD_V  = (DIV_W+1)'(PERIOD);

   state_e              state_q, state_d;
   logic [FREC_W-1:0]   Frec_q, Frec_d;
   logic [CICLOS_W-1:0] Ciclos_q, Ciclos_d;
   logic [CICLOS_W-1:0] Cout_q, Cout_d;
   logic [CTE_W-1:0]    Cte_q, Cte_d;
   logic [CTE_W-1:0]    Tout_q, Tout_d;
   logic                Err_q, Err_d;
   logic                Valid_q, Valid_d;

   logic                div_start;
   logic                div_done;
   logic                div_dbz;
   logic [DIV_W:0]      div_dvd;
   logic [DIV_W-1:0]    div_dvs;
   logic [DIV_W-1:0]    div_quot;
   logic [DIV_W-1:0]    frec_ext;
   logic [CICLOS_W-1:0] ciclos_sat;
   logic [CTE_W-1:0]    cte_sat;

   assign frec_ext   = DIV_W'(bus.Frec);
   assign div_dvs    = (state_q == DIV2) ? DIV_W'(Ciclos_q) : DIV_W'(Frec_q);
   assign ciclos_sat = CICLOS_W'(sat_u(32'(div_quot), CICLOS_W));
   assign cte_sat    = CTE_W'(sat_u(32'(div_quot), CTE_W));

   assign bus.Busy       = (state_q != IDLE);
   assign bus.Valid      = Valid_q;
   assign bus.Err        = Err_q;
   assign bus.Ciclos_pwm = Cout_q;
   assign bus.Cte        = Tout_q;

   always_comb begin
      state_d   = state_q;
      Frec_d    = Frec_q;
      Ciclos_d  = Ciclos_q;
      Cte_d     = Cte_q;
      Cout_d    = Cout_q;
      Tout_d    = Tout_q;
      Err_d     = Err_q;
      Valid_d   = 1'b0;
      div_start = 1'b0;
      div_dvd   = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.Start) begin
               Frec_d = bus.Frec;
               Err_d  = 1'b0;
               if (bus.Frec == '0) begin
                  state_d = ZERO1;
               end else begin
                  state_d   = DIV1;
                  div_start = 1'b1;
`ifdef SPWM_ROUND_EN
                  div_dvd = QUARTER_V + (DIV_W+1)'(frec_ext >> 1);
`else
                  div_dvd = QUARTER_V;
`endif
               end
            end
         end
         DIV1: begin
            if (div_done) begin
               Ciclos_d = ciclos_sat;
               Err_d    = Err_q | div_dbz;
               if (ciclos_sat == '0) begin
                  state_d = ZERO2;
               end else begin
                  // Second pass starts back-to-back on the fresh quotient.
                  state_d   = DIV2;
                  div_start = 1'b1;
`ifdef SPWM_ROUND_EN
                  div_dvd = PERIOD_V + (DIV_W+1)'(ciclos_sat >> 1);
`else
                  div_dvd = PERIOD_V;
`endif
               end
            end
         end
         DIV2: begin
            if (div_done) begin
               Cte_d   = cte_sat;
               Err_d   = Err_q | div_dbz;
               state_d = DONE;
            end
         end
         ZERO1: begin
            Ciclos_d = '0;
            Cte_d    = '0;
            Err_d    = 1'b1;
            state_d  = DONE;
         end
         ZERO2: begin
            Cte_d   = '0;
            Err_d   = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            Cout_d  = Ciclos_q;
            Tout_d  = Cte_q;
            Valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         Frec_q   <= '0;
         Ciclos_q <= '0;
         Cte_q    <= '0;
         Cout_q   <= '0;
         Tout_q   <= '0;
         Err_q    <= 1'b0;
         Valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         Frec_q   <= Frec_d;
         Ciclos_q <= Ciclos_d;
         Cte_q    <= Cte_d;
         Cout_q   <= Cout_d;
         Tout_q   <= Tout_d;
         Err_q    <= Err_d;
         Valid_q  <= Valid_d;
      end
   end

   spwm_seq_div #(
      .W (DIV_W)
   ) u_div (
      .clk_i      (Clk),
      .rst_ni     (Rst_n),
      .start_i    (div_start),
      .dividend_i (div_dvd),
      .divisor_i  (div_dvs),
      .done_o     (div_done),
      .dbz_o      (div_dbz),
      .quot_o     (div_quot)
   );
endmodule

// File: doc/spwm_param_calc.md
Name: spwm_param_calc

Overview:
- Sequential successor of the combinational PWM-parameter calculator.
- From user frequency `Frec` it computes:
  - `Ciclos_pwm = (PWM_HZ/4)/Frec`, the number of PWM carrier cycles per quarter of the generated sine.
  - `Cte = (CLK_HZ/PWM_HZ)/Ciclos_pwm`, the linear duty-cycle increment in clock ticks.
- Parametrised in clock rate, carrier rate and widths, using one shared multi-cycle restoring divider instead of combinational `/`.
- Sits between the frequency selector and the SPWM generator, with a start/valid handshake, divide-by-zero flagging and output saturation.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- PWM_HZ, 5_000, PWM carrier frequency in Hz.
- FREC_W, 8, width of `Frec`.
- CICLOS_W, 11, width of `Ciclos_pwm`.
- CTE_W, 16, width of `Cte`.
- DIV_W, 16, internal dividend/quotient width; must be ≥ clog2(CLK_HZ/PWM_HZ + 1) and ≥ CICLOS_W.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  synchronous active-low reset.
- Start  in  1  request a computation; sampled only in IDLE.
- Frec  in  FREC_W  requested sine frequency in Hz; captured on the accepted Start.
- Busy  out  1  computation in progress.
- Valid  out  1  one-cycle pulse when results are updated.
- Err  out  1  set when a division by zero occurs; held until the next accepted Start.
- Ciclos_pwm  out  CICLOS_W  carrier cycles per quarter period.
- Cte  out  CTE_W  duty increment per carrier cycle.

Behaviour:
- Reset:
  - One clock: one Clk edge with Rst_n=0 forces state IDLE.
  - All outputs go to 0: Busy=0, Valid=0, Err=0, Ciclos_pwm=0, Cte=0.
  - Reset mid-computation aborts with no Valid pulse.
- Constants: QUARTER = PWM_HZ/4 (1250); PERIOD = CLK_HZ/PWM_HZ (10000). Both are elaboration-time integers.
- IDLE:
  - Start=1 captures Frec into Frec_q and clears Err.
  - Next state is DIV1, or ZERO1 if Frec=0.
  - Busy=1 from the following cycle.
- DIV1:
  - Restoring division QUARTER/Frec_q, one quotient bit per cycle, DIV_W cycles.
  - Result saturates to 2^CICLOS_W−1 if it overflows.
  - Result is stored in Ciclos_q; then go to DIV2, or ZERO2 if Ciclos_q=0 (Frec > QUARTER).
- DIV2:
  - PERIOD/Ciclos_q, DIV_W cycles.
  - Result saturates to 2^CTE_W−1.
  - Then go to DONE.
- ZERO1: Ciclos_q=0, Cte_q=0, Err=1, go to DONE.
- ZERO2: Cte_q=0, Err=1, go to DONE.
- DONE:
  - Ciclos_pwm and Cte load from the internal registers.
  - Valid=1 for exactly this cycle, Busy=0 from the next cycle, return to IDLE.
- Latency from the Start edge to Valid high:
  - Normal path: 2·DIV_W+2 cycles (34 at default).
  - Frec=0 path: 3 cycles.
  - Frec>QUARTER path: DIV_W+3 cycles.
- Start during Busy or DONE is ignored; it is not queued.
- Start held high re-triggers on the first cycle back in IDLE.
- Outputs hold their previous results throughout a computation.
- Widths: Frec is zero-extended to DIV_W; all arithmetic is unsigned.

Optional Feature:
- Macro SPWM_ROUND_EN.
- Defined:
  - Each division rounds to nearest: dividend + divisor/2 is divided, using one extra dividend bit internally.
  - Latency is unchanged.
- Undefined: truncating division only.

Decomposition:
- Package spwm_pkg:
  - state enum (IDLE, DIV1, DIV2, ZERO1, ZERO2, DONE);
  - function computing QUARTER/PERIOD from parameters;
  - saturation helper.
- Sub-module spwm_seq_div:
  - parametrised DIV_W restoring divider with start/done and a divide-by-zero flag;
  - instantiated once and reused for both passes.

Test Plan:
- Frec=1 → after 34 cycles Valid pulse, Ciclos_pwm=1250, Cte=8, Err=0.
- Frec=60 → Ciclos_pwm=20, Cte=500.
  - With SPWM_ROUND_EN: Ciclos_pwm=21, Cte=476.
- Frec=255 → Ciclos_pwm=4, Cte=2500.
  - Then Frec=200 → Ciclos_pwm=6, Cte=1666.
- Frec=0 → Valid 3 cycles after Start, Err=1, outputs 0.
  - Next Start with Frec=10 clears Err and gives 125/80.
- Start pulsed every cycle during Busy → exactly one Valid per 34 cycles.
  - Frec changes mid-run are ignored.
- Rst_n=0 at cycle 15 of DIV1 → no Valid, all outputs 0.
  - A new Start then completes normally.
